// File: rtl/imm_decode_ctrl.sv
// rtl/imm_decode_ctrl.sv - immediate decoder feeding a DEPTH-entry decoded-instruction FIFO

// Sign source is inmeIn[14] for every width; downstream logic depends on this quirk.
module Extender (
    input  logic [27:0] inmeIn,
    input  logic [1:0]  Sel,
    output logic [31:0] inmeOut
);
    always_comb begin
        inmeOut = 32'h0;
        case (Sel)
            2'b00:   inmeOut = {{17{inmeIn[14]}}, inmeIn[14:0]};
            2'b01:   inmeOut = {{13{inmeIn[14]}}, inmeIn[18:0]};
            2'b10:   inmeOut = {{9{inmeIn[14]}},  inmeIn[22:0]};
            default: inmeOut = {{4{inmeIn[14]}},  inmeIn[27:0]};
        endcase
    end
endmodule

module imm_decode_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_instr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [1:0]  out_sel,
    output logic [31:0] out_imm,
    input  logic        flush,
    output logic        illegal,
    output logic [7:0]  illegal_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        OCC_EMPTY,
        OCC_NONEMPTY
    } occ_t;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    occ_t          occ;

    logic [31:0] instr_mem [DEPTH];
    logic [1:0]  sel_mem   [DEPTH];
    logic [31:0] imm_mem   [DEPTH];

    logic [3:0]  opcode;
    logic [1:0]  dec_sel;
    logic        dec_illegal;
    logic [31:0] ext_imm;
    logic        accept;
    logic        push;
    logic        pop;

    assign opcode = in_instr[31:28];

    always_comb begin
        dec_sel     = opcode[3:2];
        dec_illegal = (opcode == 4'hF);
    end

    Extender u_extender (
        .inmeIn  (in_instr[27:0]),
        .Sel     (dec_sel),
        .inmeOut (ext_imm)
    );

    // Occupancy is the only control state; it is derived purely from count.
    always_comb begin
        occ = (count == '0) ? OCC_EMPTY : OCC_NONEMPTY;
    end

    assign in_ready  = (count < CW'(DEPTH)) && !flush;
    assign out_valid = (occ == OCC_NONEMPTY);
    assign accept    = in_valid && in_ready;
    assign push      = accept && !dec_illegal;
    assign pop       = out_valid && out_ready;

    assign out_instr = instr_mem[rd_ptr];
    assign out_sel   = sel_mem[rd_ptr];
    assign out_imm   = imm_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            illegal     <= 1'b0;
            illegal_cnt <= 8'h00;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            illegal <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            illegal <= accept && dec_illegal;
            if (accept && dec_illegal && (illegal_cnt != 8'hFF)) begin
                illegal_cnt <= illegal_cnt + 8'h01;
            end
        end
    end

    // Storage is unreset; out_valid qualifies everything read from it.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            instr_mem[wr_ptr] <= in_instr;
            sel_mem[wr_ptr]   <= dec_sel;
            imm_mem[wr_ptr]   <= ext_imm;
        end
    end
endmodule

// File: tb/tb_imm_decode_ctrl.sv
// tb/tb_imm_decode_ctrl.sv - randomized self-checking bench for imm_decode_ctrl

module tb_imm_decode_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_sel;
    logic [31:0] out_imm;
    logic        flush;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    imm_decode_ctrl #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_instr    (in_instr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_sel     (out_sel),
        .out_imm     (out_imm),
        .flush       (flush),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  sel;
        logic [31:0] imm;
    } ent_t;

    ent_t mq[$];
    int   m_ill_cnt;
    bit   m_ill;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_sel(input logic [31:0] instr);
        return 2'(instr[31:28] / 4);
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] instr);
        int          w;
        logic [31:0] mask;
        int          op;
        op   = int'(instr[31:28]);
        w    = (op < 4) ? 15 : (op < 8) ? 19 : (op < 12) ? 23 : 28;
        mask = (32'h1 << w) - 32'h1;
        return (instr & mask) | (instr[14] ? ~mask : 32'h0);
    endfunction

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("out_instr", out_instr, mq[0].instr);
            check("out_sel", 32'(out_sel), 32'(mq[0].sel));
            check("out_imm", out_imm, mq[0].imm);
        end
        check("illegal", 32'(illegal), 32'(m_ill));
        check("illegal_cnt", 32'(illegal_cnt), 32'(m_ill_cnt));
    endtask

    // One clock: drive at negedge, check in_ready, update model at posedge, check at next negedge.
    task automatic cycle(input bit v, input logic [31:0] i, input bit r, input bit f, input bit rs);
        bit   m_ready;
        bit   acc;
        ent_t e;
        in_valid  = v;
        in_instr  = i;
        out_ready = r;
        flush     = f;
        rst       = rs;
        m_ready   = (mq.size() < DEPTH) && !f;
        #1;
        check("in_ready", 32'(in_ready), 32'(m_ready));
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_ill     = 1'b0;
            m_ill_cnt = 0;
        end else if (f) begin
            mq.delete();
            m_ill = 1'b0;
        end else begin
            acc = v && m_ready;
            if (mq.size() != 0 && r) begin
                void'(mq.pop_front());
            end
            m_ill = acc && (i[31:28] == 4'hF);
            if (acc && !m_ill) begin
                e.instr = i;
                e.sel   = ref_sel(i);
                e.imm   = ref_imm(i);
                mq.push_back(e);
            end
            if (m_ill && m_ill_cnt < 255) begin
                m_ill_cnt++;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [31:0] rand_legal();
        logic [31:0] x;
        x = $urandom;
        x[31:28] = 4'($urandom_range(0, 14));
        return x;
    endfunction

    logic [31:0] keep;

    initial begin
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst       = 1'b1;
        m_ill     = 1'b0;
        m_ill_cnt = 0;
        @(negedge clk);

        cycle(0, 32'h0, 0, 0, 1);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);

        cycle(1, 32'h0000_4001, 0, 0, 0);
        check("sel_15b", 32'(out_sel), 32'h0);
        check("imm_15b", out_imm, 32'hFFFF_C001);
        cycle(1, 32'h4003_0000, 1, 0, 0);
        check("sel_19b", 32'(out_sel), 32'h1);
        check("imm_19b", out_imm, 32'h0003_0000);
        cycle(1, 32'hC000_0005, 1, 0, 0);
        check("sel_28b", 32'(out_sel), 32'h3);
        check("imm_28b", out_imm, 32'h0000_0005);
        cycle(0, 32'h0, 1, 0, 0);

        for (int k = 0; k <= DEPTH; k++) begin
            cycle(1, rand_legal(), 0, 0, 0);
        end
        check("full_in_ready", 32'(in_ready), 32'h0);
        for (int k = 0; k < DEPTH; k++) begin
            cycle(0, 32'h0, 1, 0, 0);
        end
        check("drained", 32'(out_valid), 32'h0);

        cycle(1, 32'hF123_4567, 0, 0, 0);
        check("illegal_pulse", 32'(illegal), 32'h1);
        check("illegal_nopush", 32'(out_valid), 32'h0);
        check("illegal_cnt1", 32'(illegal_cnt), 32'h1);
        cycle(0, 32'h0, 0, 0, 0);
        check("illegal_drop", 32'(illegal), 32'h0);
        for (int k = 0; k < 300; k++) begin
            cycle(1, {4'hF, 28'($urandom)}, 0, 0, 0);
        end
        check("illegal_sat", 32'(illegal_cnt), 32'd255);

        cycle(0, 32'h0, 0, 0, 0);
        cycle(1, 32'h1000_0001, 0, 0, 0);
        keep = rand_legal();
        cycle(1, keep, 1, 0, 0);
        check("pushpop_head", out_instr, keep);
        cycle(1, rand_legal(), 0, 0, 0);
        cycle(0, 32'h0, 0, 1, 0);
        check("flush_valid", 32'(out_valid), 32'h0);
        check("flush_cnt", 32'(illegal_cnt), 32'd255);

        for (int k = 0; k < DEPTH; k++) begin
            cycle(1, rand_legal(), 0, 0, 0);
        end
        cycle(1, rand_legal(), 0, 0, 1);
        check("rst_full_valid", 32'(out_valid), 32'h0);
        check("rst_full_ready", 32'(in_ready), 32'h1);
        check("rst_full_cnt", 32'(illegal_cnt), 32'h0);

        for (int k = 0; k < 3000; k++) begin
            logic [31:0] x;
            x = $urandom;
            cycle($urandom_range(0, 3) != 0, x, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0, $urandom_range(0, 200) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_decode_ctrl.md
IMM_DECODE_CTRL -- requirements
Module: imm_decode_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2, the number of decoded-instruction buffer entries; legal values are powers of two, 2 to 8.
REQ-002 SHALL have ports clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have ports rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have ports in_instr, input, 32 bits: raw instruction; opcode = in_instr[31:28], immediate field = in_instr[27:0].
REQ-005 SHALL have ports in_valid, input, 1 bit, and in_ready, output, 1 bit: the upstream handshake; a transfer occurs when both are high.
REQ-006 SHALL have ports out_valid, output, 1 bit, and out_ready, input, 1 bit: the downstream handshake; a pop occurs when both are high.
REQ-007 SHALL have ports out_instr, output, 32 bits; out_sel, output, 2 bits; out_imm, output, 32 bits: the head buffer entry.
REQ-008 SHALL have ports flush, input, 1 bit: discard all buffered entries.
REQ-009 SHALL have ports illegal, output, 1 bit: a one-cycle pulse marking a dropped illegal opcode.
REQ-010 SHALL have ports illegal_cnt, output, 8 bits: a saturating count of illegal opcodes.

Function
REQ-011 SHALL decode the opcode to the extender select as follows:
- 0x0-0x3 -> 2'b00 (15-bit);
- 0x4-0x7 -> 2'b01 (19-bit);
- 0x8-0xB -> 2'b10 (23-bit);
- 0xC-0xE -> 2'b11 (28-bit);
- 0xF -> illegal.
REQ-012 SHALL instantiate Extender with inmeIn = in_instr[27:0] and Sel = the decoded select, and capture its inmeOut into the buffer; out_imm SHALL equal Extender output bit-for-bit, including its sign-bit source inmeIn[14] for every select.
REQ-013 SHALL implement a DEPTH-entry circular FIFO with:
- write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH;
- a count of log2(DEPTH)+1 bits.
REQ-014 SHALL drive in_ready = (count < DEPTH) and not flush; the output is combinational from registered state plus flush.
REQ-015 SHALL drive out_valid = (count != 0); out_instr, out_sel and out_imm SHALL show the entry at the read pointer (registered data, no combinational path from in_instr).
REQ-016 Latency: an instruction accepted in cycle N SHALL be presented with out_valid high in cycle N+1 when the buffer was empty.
REQ-017 A legal opcode accepted SHALL be pushed: write pointer +1 and count +1, unless a simultaneous pop occurs.
REQ-018 Simultaneous push and pop SHALL leave count unchanged while advancing both pointers.
REQ-019 An illegal opcode (0xF) accepted SHALL NOT be pushed; illegal SHALL be high exactly in cycle N+1.
REQ-020 illegal_cnt SHALL increment on each accepted illegal opcode and saturate at 255 (no wrap).
REQ-021 In full state (count == DEPTH), in_ready SHALL be low and the input SHALL be ignored; out_valid SHALL remain high.
REQ-022 In empty state, out_ready SHALL be ignored; the count SHALL never underflow.
REQ-023 flush high SHALL, on the next edge:
- set count, write pointer and read pointer to 0;
- ignore push and pop in that cycle;
- leave illegal_cnt unchanged;
- force illegal low in the following cycle.
REQ-024 The buffer data array need not be reset; outputs SHALL be qualified only by out_valid.
REQ-025 Pointer state SHALL behave as a two-state occupancy view, EMPTY (count == 0) and NONEMPTY (count > 0); there SHALL be no other control state.

Reset
REQ-026 While rst is high at a clock edge, count, write pointer, read pointer and illegal_cnt SHALL become 0, and illegal SHALL become 0.
REQ-027 With rst high, in_ready SHALL be 0 in the following cycle only if flush is high; otherwise in_ready SHALL be 1 and out_valid 0 after reset.
REQ-028 A reset asserted mid-operation SHALL discard all buffered entries; an input accepted in the reset cycle SHALL be dropped.
REQ-029 rst SHALL take priority over flush, push and pop.

Verification
REQ-030 Reset, then accept 0x0000_4001 with out_ready=0 -> next cycle: out_valid=1, out_sel=00, out_imm=0xFFFF_C001.
REQ-031 Accept 0x4003_0000 -> out_sel=01, out_imm=0x0003_0000; accept 0xC000_0005 -> out_sel=11, out_imm=0x0000_0005.
REQ-032 Hold out_ready=0 and push DEPTH legal instructions -> in_ready=0, the extra input is ignored; then pop with out_ready=1 -> entries emerge in FIFO order and pointers wrap correctly.
REQ-033 Accept 0xF123_4567 -> illegal pulses one cycle, no push (out_valid stays 0), illegal_cnt=1; 300 illegals -> illegal_cnt=255.
REQ-034 With 1 entry buffered, assert push and pop together -> count stays 1 and the new entry becomes the head; assert flush with 2 entries -> out_valid=0 next cycle and illegal_cnt is unchanged.
REQ-035 Assert rst while full and with in_valid=1 -> next cycle out_valid=0, in_ready=1, illegal_cnt=0.
